// File: rtl/rv32_mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single req/gnt/rvalid memory bus.
// One outstanding transaction; data port has priority with a bounded starvation streak.

package rv32_mem_pkg;
  typedef struct packed {
    logic        do_request;
    logic [31:0] addr;
    logic        op;      // 1 = write, 0 = read
    logic [31:0] data;
    logic [3:0]  strobe;
  } memory_request_t;
endpackage

// state  | meaning
// IDLE   | pick a winner, latch its request
// REQ    | mem_req held from latched registers until mem_gnt
// WAIT   | waiting for mem_rvalid, capture read data
// RESP   | done pulse for the owner (unless abandoned)
module rv32_mem_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  memory_request_t instr_request,
  output logic            instr_request_done,
  output logic [31:0]     instr,
  input  memory_request_t data_request,
  output logic            data_request_done,
  output logic [31:0]     data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(DATA_STREAK_MAX);

  state_t     state;
  logic       owner_data;
  logic       abandon;
  logic [3:0] streak;

  logic instr_wins;
  logic owner_req;

  // The instruction port is read-only; its write fields are never used.
  logic unused_instr_fields;
  assign unused_instr_fields = ^{instr_request.op, instr_request.data, instr_request.strobe};

  always_comb begin
    instr_wins = 1'b0;
    owner_req  = 1'b0;
    instr_wins = instr_request.do_request &&
                 (!data_request.do_request || streak == STREAK_MAX);
    owner_req  = owner_data ? data_request.do_request : instr_request.do_request;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      owner_data         <= 1'b0;
      abandon            <= 1'b0;
      streak             <= 4'd0;
      mem_req            <= 1'b0;
      mem_we             <= 1'b0;
      mem_addr           <= 32'd0;
      mem_wdata          <= 32'd0;
      mem_be             <= 4'd0;
      instr_request_done <= 1'b0;
      data_request_done  <= 1'b0;
      instr              <= 32'd0;
      data               <= 32'd0;
    end else begin
      instr_request_done <= 1'b0;
      data_request_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!instr_request.do_request) streak <= 4'd0;
          if (instr_wins) begin
            owner_data <= 1'b0;
            mem_addr   <= instr_request.addr;
            mem_we     <= 1'b0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'hF;
            streak     <= 4'd0;
            mem_req    <= 1'b1;
            state      <= S_REQ;
          end else if (data_request.do_request) begin
            owner_data <= 1'b1;
            mem_addr   <= data_request.addr;
            mem_we     <= data_request.op;
            mem_wdata  <= data_request.data;
            mem_be     <= data_request.op ? data_request.strobe : 4'hF;
            if (instr_request.do_request && streak != STREAK_MAX)
              streak <= streak + 4'd1;
            mem_req    <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (!owner_req) abandon <= 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!owner_req) abandon <= 1'b1;
          if (mem_rvalid) begin
            state <= S_RESP;
            // A drop in this same cycle also counts as an abandon.
            if (!abandon && owner_req) begin
              if (owner_data) begin
                data_request_done <= 1'b1;
                if (!mem_we) data <= mem_rdata;
              end else begin
                instr_request_done <= 1'b1;
                instr              <= mem_rdata;
              end
            end
          end
        end
        S_RESP: begin
          abandon <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
